uart_rx: RTL

UART receiver; the counterpart of the transmit shift-register path.
- Deserialises an asynchronous serial line, LSB first: start bit (0), DATA_BITS data bits, optional parity bit, one stop bit (1).
- Samples each bit at mid-period using an internal baud counter.
- Presents each received byte with a one-cycle valid pulse plus error flags.
- Sits between the board RX pin and the consumer logic in the uart block.

---
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, LSB-first deserialiser with error flags.
// Optional parity bit/check built only when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam logic [15:0] FULL_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_MAX = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q, rx_prev_d;
  logic [1:0]             settle_q, settle_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   full_hit, half_hit;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  logic                   mismatch_q, mismatch_d;
  logic                   parity_err_q, parity_err_d;
`endif

  assign full_hit = (cnt_q == FULL_MAX);
  assign half_hit = (cnt_q == HALF_MAX);

  // The edge register only trusts rx_s once the synchroniser has flushed its
  // reset value, so a line held low through reset never looks like a start edge.
  always_comb begin
    settle_d  = {settle_q[0], 1'b1};
    rx_prev_d = rx_s_q & settle_q[1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    mismatch_d   = mismatch_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        bit_idx_d = 4'd0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (half_hit) begin
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (full_hit) begin
          cnt_d     = 16'd0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_hit) begin
          mismatch_d = rx_s_q ^ (^shift_q) ^ ODD_BIT;
          state_d    = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (full_hit) begin
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = mismatch_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        state_d = rx_s_q ? S_IDLE : S_BREAK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every state change restarts the baud count; IDLE and BREAK hold it at zero.
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_BREAK)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b0;
      settle_q    <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 4'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mismatch_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_prev_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      mismatch_q   <= mismatch_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
